// File: rtl/seq_alu_pkg.sv
// Shared definitions for the registered ALU with iterative multiply/divide:
// ALUFun codes, FSM state encoding and op classification.
package seq_alu_pkg;

  localparam logic [5:0] FunAdd   = 6'b000000;
  localparam logic [5:0] FunSub   = 6'b000001;
  localparam logic [5:0] FunAnd   = 6'b011000;
  localparam logic [5:0] FunOr    = 6'b011110;
  localparam logic [5:0] FunXor   = 6'b010110;
  localparam logic [5:0] FunNor   = 6'b010001;
  localparam logic [5:0] FunPassA = 6'b011010;
  localparam logic [5:0] FunSll   = 6'b100000;
  localparam logic [5:0] FunSrl   = 6'b100001;
  localparam logic [5:0] FunSra   = 6'b100011;
  localparam logic [5:0] FunEq    = 6'b110011;
  localparam logic [5:0] FunNeq   = 6'b110001;
  localparam logic [5:0] FunLt    = 6'b110101;
  localparam logic [5:0] FunLez   = 6'b111101;
  localparam logic [5:0] FunLtz   = 6'b111011;
  localparam logic [5:0] FunGtz   = 6'b111111;
  localparam logic [5:0] FunMult  = 6'b001000;
  localparam logic [5:0] FunDiv   = 6'b001001;

  typedef enum logic {StIdle, StBusy} state_e;

  function automatic logic is_multicycle(input logic [5:0] alu_fun);
    return (alu_fun == FunMult) || (alu_fun == FunDiv);
  endfunction

endpackage

// File: rtl/seq_alu_mdu_if.sv
// Issue/result bundle of seq_alu_mdu; the requester holds master, the unit slave.
interface seq_alu_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       alu_fun;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] hi;
  logic             v;
  logic             n;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, alu_fun, sign, a, b,
    input  in_ready, out_valid, z, hi, v, n, zero, div_by_zero
  );

  modport slave (
    input  in_valid, alu_fun, sign, a, b,
    output in_ready, out_valid, z, hi, v, n, zero, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per edge, sign correction presented with done.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q, lo_q, opb_q, a_q;
  logic             is_div_q, neg_lo_q, neg_hi_q, dz_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, rem_shl, rem_sub;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_mag   = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag   = (sign && b[WIDTH-1]) ? -b : b;
  assign add_sum = lo_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
  assign rem_shl = {acc_q, lo_q[WIDTH-1]};
  // Top bit set means the trial subtraction borrowed, so the remainder is restored.
  assign rem_sub = rem_shl - {1'b0, opb_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= a_mag;
      opb_q    <= b_mag;
      a_q      <= a;
      is_div_q <= is_div;
      neg_lo_q <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_q <= sign && a[WIDTH-1];
      dz_q     <= is_div && (b == '0);
    end else if (busy_q) begin
      if (cnt_q == CntW'(WIDTH)) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (is_div_q) begin
          if (!rem_sub[WIDTH]) begin
            acc_q <= rem_sub[WIDTH-1:0];
            lo_q  <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= rem_shl[WIDTH-1:0];
            lo_q  <= {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {acc_q, lo_q} <= {add_sum, lo_q[WIDTH-1:1]};
        end
      end
    end
  end

  assign done = busy_q && (cnt_q == CntW'(WIDTH));
  assign dz   = dz_q;

  always_comb begin
    prod_neg = -{acc_q, lo_q};
    lo       = lo_q;
    hi       = acc_q;
    if (dz_q) begin
      lo = '1;
      hi = a_q;
    end else if (is_div_q) begin
      lo = neg_lo_q ? -lo_q : lo_q;
      hi = neg_hi_q ? -acc_q : acc_q;
    end else if (neg_lo_q) begin
      {hi, lo} = prod_neg;
    end
  end

endmodule

// File: rtl/seq_alu_mdu.sv
// Registered EX-stage ALU: single-cycle ops complete on the accept edge, mult/div
// run in mdu_iter while in_ready is held low.
module seq_alu_mdu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          rst_n,
  seq_alu_mdu_if.slave bus
);
  state_e state_q, state_d;

  logic             accept, start, mdu_done, mdu_dz;
  logic [WIDTH-1:0] mdu_lo, mdu_hi;
  logic [WIDTH-1:0] alu_z;
  logic             alu_v, alu_n;
  logic [WIDTH:0]   sum, diff;
  logic [SHAMT_W-1:0] shamt;
  logic             a_msb, b_msb;
  logic             out_valid_q, v_q, n_q, dz_q;
  logic [WIDTH-1:0] z_q, hi_q;

  assign bus.in_ready = (state_q == StIdle);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start        = accept && is_multicycle(bus.alu_fun);
  assign shamt        = bus.a[SHAMT_W-1:0];
  assign a_msb        = bus.a[WIDTH-1];
  assign b_msb        = bus.b[WIDTH-1];
  assign sum          = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff         = {1'b0, bus.a} - {1'b0, bus.b};

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .is_div(bus.alu_fun == FunDiv),
    .sign  (bus.sign),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mdu_done),
    .lo    (mdu_lo),
    .hi    (mdu_hi),
    .dz    (mdu_dz)
  );

  always_comb begin
    alu_z = '0;
    alu_v = 1'b0;
    alu_n = 1'b0;
    case (bus.alu_fun)
      FunAdd: begin
        alu_z = sum[WIDTH-1:0];
        if (bus.sign) begin
          alu_v = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
          alu_n = sum[WIDTH-1];
        end else begin
          alu_v = sum[WIDTH];
        end
      end
      FunSub: begin
        alu_z = diff[WIDTH-1:0];
        if (bus.sign) begin
          alu_v = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
          alu_n = diff[WIDTH-1];
        end else begin
          alu_v = diff[WIDTH];
          alu_n = diff[WIDTH];
        end
      end
      FunAnd:   alu_z = bus.a & bus.b;
      FunOr:    alu_z = bus.a | bus.b;
      FunXor:   alu_z = bus.a ^ bus.b;
      FunNor:   alu_z = ~(bus.a | bus.b);
      FunPassA: alu_z = bus.a;
      FunSll:   alu_z = bus.b << shamt;
      FunSrl:   alu_z = bus.b >> shamt;
      FunSra:   alu_z = WIDTH'($signed(bus.b) >>> shamt);
      FunEq:    alu_z = WIDTH'(bus.a == bus.b);
      FunNeq:   alu_z = WIDTH'(bus.a != bus.b);
      FunLt:    alu_z = WIDTH'(bus.sign ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b));
      FunLez:   alu_z = WIDTH'(a_msb || (bus.a == '0));
      FunLtz:   alu_z = WIDTH'(a_msb);
      FunGtz:   alu_z = WIDTH'(!a_msb && (bus.a != '0));
      default:  alu_z = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StBusy;
      StBusy: if (mdu_done) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      hi_q        <= '0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept && !start) begin
        out_valid_q <= 1'b1;
        z_q         <= alu_z;
        hi_q        <= '0;
        v_q         <= alu_v;
        n_q         <= alu_n;
        dz_q        <= 1'b0;
      end else if ((state_q == StBusy) && mdu_done) begin
        out_valid_q <= 1'b1;
        z_q         <= mdu_lo;
        hi_q        <= mdu_hi;
        v_q         <= 1'b0;
        n_q         <= 1'b0;
        dz_q        <= mdu_dz;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.z           = z_q;
  assign bus.hi          = hi_q;
  assign bus.v           = v_q;
  assign bus.n           = n_q;
  assign bus.zero        = (z_q == '0);
  assign bus.div_by_zero = dz_q;

endmodule
